// File: rtl/skid_pipe_reg.sv
// skid_pipe_reg: two-entry (main + skid) pipeline register with a valid/ready
// handshake on both sides. All handshake outputs and out_data come straight
// from flops, so neither out_ready nor in_data has a combinational path to an
// output. A synchronous flush discards both entries.
//
// Optional feature: define SKID_PIPE_REG_STALL_CNT_EN to build a 16-bit
// saturating producer-stall counter on stall_cycles. When the macro is not
// defined, stall_cycles is tied to zero and no counter flops are built.
module skid_pipe_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [15:0]      stall_cycles
);

  // The state encoding is the occupancy count itself.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] main_r;
  logic [WIDTH-1:0] skid_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             push_s;
  logic             pop_s;

  // The handshake events use only registered outputs and the partner's strobe.
  assign push_s = in_valid & in_ready_r;
  assign pop_s  = out_valid_r & out_ready;

  // Occupancy FSM: moves data between producer, main and skid registers and
  // keeps the registered in_ready/out_valid consistent with the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_EMPTY;
      main_r      <= RESET_VAL;
      skid_r      <= RESET_VAL;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else if (flush) begin
      // Data registers deliberately keep their contents; only the entries are dropped.
      state_r     <= ST_EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (push_s) begin
            main_r      <= in_data;
            state_r     <= ST_ONE;
            out_valid_r <= 1'b1;
          end
        end
        ST_ONE: begin
          if (push_s && !pop_s) begin
            skid_r     <= in_data;
            state_r    <= ST_FULL;
            in_ready_r <= 1'b0;
          end else if (push_s && pop_s) begin
            main_r <= in_data;
          end else if (pop_s) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only a pop can happen.
          if (pop_s) begin
            main_r     <= skid_r;
            state_r    <= ST_ONE;
            in_ready_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_EMPTY;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = main_r;
  assign occupancy = state_r;

`ifdef SKID_PIPE_REG_STALL_CNT_EN
  logic [15:0] stall_cnt_r;

  // Producer-stall counter: counts cycles where data is offered but refused, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= 16'h0000;
    end else if (in_valid && !in_ready_r && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cycles = stall_cnt_r;
`else
  assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_skid_pipe_reg.sv
// Self-checking bench for skid_pipe_reg: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_skid_pipe_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  occupancy;
  logic [15:0] stall_cycles;

  int errors = 0;
  int checks = 0;

  // Reference model: FIFO contents (head first) and stall count.
  logic [31:0] model_q[$];
  int          model_stall = 0;
  bit          model_push  = 1'b0;

  skid_pipe_reg #(
    .WIDTH    (32),
    .RESET_VAL(32'hDEADBEEF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .occupancy   (occupancy),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int n;
    n = model_q.size();
    check_val("occupancy", {30'd0, occupancy}, n);
    check_val("out_valid", {31'd0, out_valid}, (n > 0) ? 32'd1 : 32'd0);
    check_val("in_ready", {31'd0, in_ready}, (n < 2) ? 32'd1 : 32'd0);
    check_val("stall_cycles", {16'd0, stall_cycles}, model_stall);
    if (n > 0) begin
      check_val("out_data", out_data, model_q[0]);
    end
  endtask

  // Drive one cycle, advance the model, clock, and compare on the falling edge.
  task automatic cycle(input bit rst, input bit fl, input bit v, input logic [31:0] d, input bit rdy);
    bit do_push;
    bit do_pop;
    reset     = rst;
    flush     = fl;
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    model_push = 1'b0;
    if (rst) begin
      model_q.delete();
      model_stall = 0;
    end else begin
`ifdef SKID_PIPE_REG_STALL_CNT_EN
      if (v && model_q.size() == 2 && model_stall < 65535) model_stall++;
`endif
      if (fl) begin
        model_q.delete();
      end else begin
        do_push = v && (model_q.size() < 2);
        do_pop  = rdy && (model_q.size() > 0);
        if (do_pop) void'(model_q.pop_front());
        if (do_push) model_q.push_back(d);
        model_push = do_push;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    bit          hv;
    logic [31:0] hd;
    bit          r;
    bit          f;
    bit          v;
    bit          rdy;
    logic [31:0] d;

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0;

    // Reset state
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 32'h12345678, 1'b1);
    check_val("reset_data", out_data, 32'hDEADBEEF);
    check_val("reset_occ", {30'd0, occupancy}, 32'd0);

    // Streaming 1..4 with out_ready high
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b0, 1'b0, 1'b1, i, 1'b1);
      check_val("stream_data", out_data, i);
    end
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

    // Back-pressure: 5,6 fill, 7 waits three cycles, then drain
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'd5, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'd6, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 32'd7, 1'b0);
    check_val("bp_in_ready", {31'd0, in_ready}, 32'd0);
    cycle(1'b0, 1'b0, 1'b1, 32'd7, 1'b1);
    check_val("bp_head6", out_data, 32'd6);
    cycle(1'b0, 1'b0, 1'b1, 32'd7, 1'b1);
    check_val("bp_head7", out_data, 32'd7);
`ifdef SKID_PIPE_REG_STALL_CNT_EN
    check_val("bp_stall", {16'd0, stall_cycles}, 32'd4);
`else
    check_val("bp_stall", {16'd0, stall_cycles}, 32'd0);
`endif
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

    // Flush while full with a word offered
    cycle(1'b0, 1'b0, 1'b1, 32'd10, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'd11, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 32'd99, 1'b1);
    check_val("flush_occ", {30'd0, occupancy}, 32'd0);
    check_val("flush_valid", {31'd0, out_valid}, 32'd0);
    check_val("flush_keep", out_data, 32'd10);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    check_val("flush_nocap", {30'd0, occupancy}, 32'd0);

    // Randomized traffic with occasional reset/flush; producer holds refused data
    hv = 1'b0;
    hd = 32'd0;
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(63) == 0);
      f   = ($urandom_range(31) == 0);
      rdy = ($urandom_range(2) != 0);
      if (hv) begin
        v = 1'b1;
        d = hd;
      end else begin
        v = ($urandom_range(3) != 0);
        d = $urandom;
      end
      cycle(r, f, v, d, rdy);
      hv = v && !model_push && !r && !f;
      hd = d;
    end

    // Saturation of the stall counter
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'hA, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'hB, 1'b0);
`ifdef SKID_PIPE_REG_STALL_CNT_EN
    for (int i = 0; i < 70000; i++) cycle(1'b0, 1'b0, 1'b1, 32'hC, 1'b0);
    check_val("stall_sat", {16'd0, stall_cycles}, 32'h0000FFFF);
`else
    for (int i = 0; i < 200; i++) cycle(1'b0, 1'b0, 1'b1, 32'hC, 1'b0);
    check_val("stall_zero", {16'd0, stall_cycles}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
